// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between buffered UART FIFOs and a combinational ALU:
// pops operand A, operand B and opcode, executes, pushes the result.
module uart_alu_ctrl #(
   parameter int DBIT   = 8,
   parameter int OP_W   = 6,
   parameter int TOUT   = 1000000,
   parameter int TOUT_W = 20
) (
   input  logic            i_clk,
   input  logic            reset,
   input  logic            i_rx_empty,
   input  logic [DBIT-1:0] i_r_data,
   output logic            o_rd_uart,
   input  logic            i_tx_full,
   output logic [DBIT-1:0] o_w_data,
   output logic            o_wr_uart,
   output logic [DBIT-1:0] o_data_a,
   output logic [DBIT-1:0] o_data_b,
   output logic [OP_W-1:0] o_opcode,
   input  logic [DBIT-1:0] i_alu_result,
   output logic            o_busy,
   output logic            o_timeout
);

   typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, SEND} state_t;

   state_t            state, state_next;
   logic [TOUT_W-1:0] tout_cnt, tout_cnt_next;
   logic              rd_req, wr_req, tout_hit;

   always_comb begin
      state_next    = state;
      tout_cnt_next = '0;
      rd_req        = 1'b0;
      wr_req        = 1'b0;
      tout_hit      = 1'b0;
      case (state)
         RX_A: begin
            rd_req = !i_rx_empty;
            if (!i_rx_empty) state_next = RX_B;
         end
         RX_B, RX_OP: begin
            rd_req = !i_rx_empty;
            // A pop arriving on the limit cycle still wins over the timeout
            if (!i_rx_empty) begin
               state_next = (state == RX_B) ? RX_OP : EXEC;
            end else if (tout_cnt == TOUT_W'(TOUT - 1)) begin
               tout_hit   = 1'b1;
               state_next = RX_A;
            end else begin
               tout_cnt_next = tout_cnt + TOUT_W'(1);
            end
         end
         EXEC: state_next = SEND;
         SEND: begin
            wr_req = !i_tx_full;
            if (!i_tx_full) state_next = RX_A;
         end
         default: state_next = RX_A;
      endcase
   end

   // Strobes are suppressed while reset is held so no FIFO word is lost
   assign o_rd_uart = reset & rd_req;
   assign o_wr_uart = reset & wr_req;
   assign o_busy    = (state != RX_A);

   always_ff @(posedge i_clk) begin
      if (!reset) begin
         state     <= RX_A;
         tout_cnt  <= '0;
         o_timeout <= 1'b0;
         o_data_a  <= '0;
         o_data_b  <= '0;
         o_opcode  <= '0;
         o_w_data  <= '0;
      end else begin
         state     <= state_next;
         tout_cnt  <= tout_cnt_next;
         o_timeout <= tout_hit;
         if (rd_req) begin
            case (state)
               RX_A:    o_data_a <= i_r_data;
               RX_B:    o_data_b <= i_r_data;
               RX_OP:   o_opcode <= i_r_data[OP_W-1:0];
               default: ;
            endcase
         end
         if (state == EXEC) o_w_data <= i_alu_result;
      end
   end

endmodule
